// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and default widths for the LEGv8 MEM stage.
package mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_REG_W = 5;
   localparam int DEF_TIMEOUT_CYCLES = 16;
   localparam logic [2:0] ALIGN_MASK = 3'b111;
endpackage

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register; a bubble loads all-zero so writeback never repeats.
module mem_wb_pipe
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W = DEF_REG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble,
   input  logic              reg_write,
   input  logic              mem2reg,
   input  logic [DATA_W-1:0] read_data,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [REG_W-1:0]  write_reg,
   output logic              wb_reg_write,
   output logic              wb_mem2reg,
   output logic [DATA_W-1:0] wb_read_data,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [REG_W-1:0]  wb_write_reg
);
   always_ff @(posedge clk or posedge rst)
      if (rst || bubble) begin
         wb_reg_write <= 1'b0;
         wb_mem2reg <= 1'b0;
         wb_read_data <= '0;
         wb_alu_result <= '0;
         wb_write_reg <= '0;
      end else begin
         wb_reg_write <= reg_write;
         wb_mem2reg <= mem2reg;
         wb_read_data <= read_data;
         wb_alu_result <= alu_result;
         wb_write_reg <= write_reg;
      end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LEGv8 MEM stage with branch resolve, stalling dmem handshake,
// alignment/timeout faults and the MEM/WB register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W = DEF_REG_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CHECK_ALIGN = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ZeroBranch_in,
   input  logic              UnconBranch_in,
   input  logic              memRead_in,
   input  logic              memWrite_in,
   input  logic              regWrite_in,
   input  logic              mem2Reg_in,
   input  logic [DATA_W-1:0] shifted_PC_in,
   input  logic              alu_zero_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] write_data_mem_in,
   input  logic [REG_W-1:0]  write_reg_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              stall,
   output logic              pc_src,
   output logic [DATA_W-1:0] branch_target,
   output logic              mem_fault,
   output logic              wb_regWrite_out,
   output logic              wb_mem2Reg_out,
   output logic [DATA_W-1:0] wb_read_data_out,
   output logic [DATA_W-1:0] wb_alu_result_out,
   output logic [REG_W-1:0]  wb_write_reg_out
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] rdata_q;
   logic req_we, to_q, op, bad, timeout, bubble, fault_n;
   assign op = memRead_in | memWrite_in;
   assign bad = (memRead_in & memWrite_in) | ((CHECK_ALIGN != 0) && ((alu_result_in[2:0] & ALIGN_MASK) != 3'b000));
   assign timeout = !dmem_ready && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign dmem_req = state == WAIT;
   assign dmem_we = req_we & dmem_req;
   assign pc_src = (UnconBranch_in | (ZeroBranch_in & alu_zero_in)) & !stall;
   assign branch_target = shifted_PC_in;
   always_comb begin
      state_n = state;
      stall = 1'b0;
      bubble = 1'b0;
      fault_n = 1'b0;
      case (state)
         IDLE: begin
            stall = op && !bad;
            bubble = op;
            fault_n = op && bad;
            state_n = (op && !bad) ? WAIT : IDLE;
         end
         WAIT: begin
            stall = 1'b1;
            bubble = 1'b1;
            fault_n = timeout;
            state_n = (dmem_ready || timeout) ? DONE : WAIT;
         end
         DONE: begin
            bubble = to_q;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state <= IDLE;
         cnt <= '0;
         req_we <= 1'b0;
         dmem_addr <= '0;
         dmem_wdata <= '0;
         rdata_q <= '0;
         to_q <= 1'b0;
         mem_fault <= 1'b0;
      end else begin
         state <= state_n;
         mem_fault <= fault_n;
         if (state == IDLE && op && !bad) begin
            dmem_addr <= alu_result_in;
            dmem_wdata <= write_data_mem_in;
            req_we <= memWrite_in;
            cnt <= '0;
            to_q <= 1'b0;
         end
         if (state == WAIT) begin
            cnt <= cnt + 1'b1;
            to_q <= timeout;
            if (dmem_ready) rdata_q <= req_we ? '0 : dmem_rdata;
         end
      end
   // EX/MEM is frozen while stalled, so in DONE the inputs still describe the finished op
   mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) u_wb (
      .clk(CLK),
      .rst(RESET),
      .bubble(bubble),
      .reg_write(regWrite_in),
      .mem2reg(mem2Reg_in),
      .read_data(state == DONE ? rdata_q : '0),
      .alu_result(alu_result_in),
      .write_reg(write_reg_in),
      .wb_reg_write(wb_regWrite_out),
      .wb_mem2reg(wb_mem2Reg_out),
      .wb_read_data(wb_read_data_out),
      .wb_alu_result(wb_alu_result_out),
      .wb_write_reg(wb_write_reg_out)
   );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a writeback scoreboard checked by an independent monitor.
module tb_mem_stage;
   localparam int TO = 16;
   logic CLK = 1'b0, RESET = 1'b1;
   logic ZeroBranch_in, UnconBranch_in, memRead_in, memWrite_in, regWrite_in, mem2Reg_in, alu_zero_in;
   logic [63:0] shifted_PC_in, alu_result_in, write_data_mem_in, dmem_rdata;
   logic [4:0] write_reg_in;
   logic dmem_ready = 1'b0;
   logic dmem_req, dmem_we, stall, pc_src, mem_fault, wb_regWrite_out, wb_mem2Reg_out;
   logic [63:0] dmem_addr, dmem_wdata, branch_target, wb_read_data_out, wb_alu_result_out;
   logic [4:0] wb_write_reg_out;
   logic [134:0] sb[$];
   int tests = 0, fails = 0;

   mem_stage dut (
      .CLK(CLK), .RESET(RESET), .ZeroBranch_in(ZeroBranch_in), .UnconBranch_in(UnconBranch_in),
      .memRead_in(memRead_in), .memWrite_in(memWrite_in), .regWrite_in(regWrite_in),
      .mem2Reg_in(mem2Reg_in), .shifted_PC_in(shifted_PC_in), .alu_zero_in(alu_zero_in),
      .alu_result_in(alu_result_in), .write_data_mem_in(write_data_mem_in), .write_reg_in(write_reg_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall(stall), .pc_src(pc_src),
      .branch_target(branch_target), .mem_fault(mem_fault), .wb_regWrite_out(wb_regWrite_out),
      .wb_mem2Reg_out(wb_mem2Reg_out), .wb_read_data_out(wb_read_data_out),
      .wb_alu_result_out(wb_alu_result_out), .wb_write_reg_out(wb_write_reg_out)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic nop_in();
      ZeroBranch_in = 0; UnconBranch_in = 0; memRead_in = 0; memWrite_in = 0;
      regWrite_in = 0; mem2Reg_in = 0; alu_zero_in = 0; shifted_PC_in = 0;
      alu_result_in = 0; write_data_mem_in = 0; write_reg_in = 0; dmem_rdata = 0;
   endtask

   task automatic wb_zero(input string nm);
      chk(nm, {wb_regWrite_out, wb_mem2Reg_out, wb_write_reg_out}, 0);
      chk(nm, wb_read_data_out | wb_alu_result_out, 0);
   endtask

   // n_wait = WAIT cycle carrying dmem_ready; 0 means ready never comes (timeout)
   task automatic mem_op(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [4:0] wreg, input int n_wait, input logic [63:0] rd);
      int n_st, n_rq;
      bit done, to;
      to = (n_wait == 0);
      @(posedge CLK); #1;
      nop_in();
      memRead_in = !wr; memWrite_in = wr; regWrite_in = !wr; mem2Reg_in = !wr;
      alu_result_in = addr; write_data_mem_in = wd; write_reg_in = wreg;
      if (!to) sb.push_back({!wr, !wr, (wr ? 64'h0 : rd), addr, wreg});
      @(negedge CLK);
      n_st = int'(stall); n_rq = int'(dmem_req);
      done = 0;
      for (int k = 1; k < 40 && !done; k++) begin
         @(posedge CLK); #1;
         dmem_ready = (k == n_wait);
         dmem_rdata = (k == n_wait) ? rd : 64'h0BAD_0BAD;
         @(negedge CLK);
         if (dmem_req) begin
            n_rq++;
            chk("req_addr", dmem_addr, addr);
            chk("req_we", dmem_we, wr);
            if (wr) chk("req_wdata", dmem_wdata, wd);
         end
         if (stall) n_st++;
         else done = 1;
      end
      chk("done_reached", done, 1);
      chk("stall_cycles", n_st, to ? 1 + TO : 1 + n_wait);
      chk("req_cycles", n_rq, to ? TO : n_wait);
      chk("done_fault", mem_fault, to);
      chk("done_we", dmem_we, 0);
      @(posedge CLK); #1;
      nop_in(); dmem_ready = 0;
      @(negedge CLK);
      chk("fault_end", mem_fault, 0);
      chk("idle_stall", stall, 0);
      if (to) wb_zero("timeout_bubble");
   endtask

   task automatic bad_op(input logic rd, input logic wr, input logic [63:0] addr);
      @(posedge CLK); #1;
      nop_in();
      memRead_in = rd; memWrite_in = wr; regWrite_in = rd; mem2Reg_in = rd;
      alu_result_in = addr; write_reg_in = 5'd4;
      @(negedge CLK);
      chk("bad_stall", stall, 0);
      chk("bad_req", dmem_req, 0);
      chk("bad_fault_early", mem_fault, 0);
      @(posedge CLK); #1;
      nop_in();
      @(negedge CLK);
      chk("bad_fault", mem_fault, 1);
      wb_zero("bad_bubble");
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("bad_fault_end", mem_fault, 0);
   endtask

   always begin
      @(negedge CLK);
      if (!RESET && (wb_regWrite_out || wb_mem2Reg_out || wb_write_reg_out != 0 ||
                     wb_read_data_out != 0 || wb_alu_result_out != 0)) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL wb_spurious: got alu %0h reg %0d, expected nothing", wb_alu_result_out, wb_write_reg_out);
         end else begin
            logic [134:0] e;
            e = sb.pop_front();
            chk("wb_regWrite", wb_regWrite_out, e[134]);
            chk("wb_mem2Reg", wb_mem2Reg_out, e[133]);
            chk("wb_read_data", wb_read_data_out, e[132:69]);
            chk("wb_alu_result", wb_alu_result_out, e[68:5]);
            chk("wb_write_reg", wb_write_reg_out, e[4:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nop_in();
      repeat (2) @(posedge CLK);
      #1 RESET = 0;
      @(negedge CLK);
      chk("rst_stall", stall, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_fault", mem_fault, 0);
      wb_zero("rst_wb");
      @(posedge CLK); #1;
      UnconBranch_in = 1; shifted_PC_in = 64'h100;
      @(negedge CLK);
      chk("b_pc_src", pc_src, 1);
      chk("b_target", branch_target, 64'h100);
      @(posedge CLK); #1;
      nop_in(); ZeroBranch_in = 1; shifted_PC_in = 64'h200;
      @(negedge CLK);
      chk("cbz_nz_pc_src", pc_src, 0);
      chk("cbz_target", branch_target, 64'h200);
      @(posedge CLK); #1;
      alu_zero_in = 1;
      @(negedge CLK);
      chk("cbz_z_pc_src", pc_src, 1);
      @(posedge CLK); #1;
      nop_in(); regWrite_in = 1; alu_result_in = 64'h1234; write_reg_in = 5'd3;
      sb.push_back({1'b1, 1'b0, 64'h0, 64'h1234, 5'd3});
      @(negedge CLK);
      chk("alu_stall", stall, 0);
      mem_op(1'b0, 64'h40, 64'h0, 5'd9, 3, 64'hDEAD_BEEF);
      mem_op(1'b1, 64'h08, 64'h55, 5'd5, 1, 64'h0);
      bad_op(1'b1, 1'b0, 64'h43);
      bad_op(1'b1, 1'b1, 64'h10);
      mem_op(1'b0, 64'h18, 64'h0, 5'd6, 0, 64'h0);
      @(posedge CLK); #1;
      nop_in(); memRead_in = 1; regWrite_in = 1; alu_result_in = 64'h80; write_reg_in = 5'd2;
      repeat (3) @(posedge CLK);
      #2 chk("pre_rst_req", dmem_req, 1);
      #1 RESET = 1; dmem_ready = 1; nop_in();
      #1;
      chk("mid_rst_req", dmem_req, 0);
      chk("mid_rst_stall", stall, 0);
      wb_zero("mid_rst_wb");
      @(posedge CLK); #1;
      RESET = 0; dmem_ready = 0;
      @(negedge CLK);
      chk("post_rst_req", dmem_req, 0);
      chk("post_rst_fault", mem_fault, 0);
      mem_op(1'b0, 64'h20, 64'h0, 5'd11, 1, 64'h0123_4567_89AB_CDEF);
      repeat (3) @(negedge CLK);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
LEGv8 pipeline MEM stage. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Resolves branches.
- Runs a multi-cycle data-memory request/ready handshake, stalling upstream stages while it waits.
- Checks alignment and timeout faults.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
DATA_W, 64, data and address width
REG_W, 5, register index width
TIMEOUT_CYCLES, 16, WAIT cycles without dmem_ready before fault
CHECK_ALIGN, 1, 1 = fault on addr[2:0]!=0

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
ZeroBranch_in  in  1  CBZ-type branch
UnconBranch_in  in  1  unconditional branch
memRead_in  in  1  load
memWrite_in  in  1  store
regWrite_in  in  1  writeback enable
mem2Reg_in  in  1  writeback selects memory data
shifted_PC_in  in  64  branch target
alu_zero_in  in  1  ALU zero flag
alu_result_in  in  64  memory address / ALU value
write_data_mem_in  in  64  store data
write_reg_in  in  5  destination register
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  64  request address
dmem_wdata  out  64  store data
dmem_rdata  in  64  load data, valid with dmem_ready
dmem_ready  in  1  request complete
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
pc_src  out  1  take branch
branch_target  out  64  equals shifted_PC_in
mem_fault  out  1  one-cycle fault pulse
wb_regWrite_out  out  1  MEM/WB control
wb_mem2Reg_out  out  1  MEM/WB control
wb_read_data_out  out  64  MEM/WB load data
wb_alu_result_out  out  64  MEM/WB ALU value
wb_write_reg_out  out  5  MEM/WB destination

Behaviour:
- Clocking and reset: one clock CLK; RESET asynchronous, active-high.
- Reset values:
  - State IDLE.
  - All registered outputs and the timeout counter 0.
  - dmem_req and stall drop immediately, including mid-WAIT; any in-flight dmem_ready is ignored.
- Definitions:
  - op = memRead_in|memWrite_in.
  - bad = (memRead_in&memWrite_in) | (CHECK_ALIGN & alu_result_in[2:0]!=0).
- State IDLE:
  - op&!bad: stall=1; latch addr, wdata and we=memWrite_in into request registers; go WAIT.
  - op&bad: stall=0; no request; MEM/WB loads a bubble; mem_fault=1 next cycle.
  - !op: stall=0; pass-through.
- State WAIT:
  - stall=1; dmem_req=1; dmem_addr, dmem_we and dmem_wdata held stable from the latched request registers.
  - dmem_ready=1: capture dmem_rdata (loads only); go DONE.
  - Counter increments each WAIT cycle. Counter reaches TIMEOUT_CYCLES without ready: drop request, set mem_fault next cycle, go DONE flagged as a bubble.
- State DONE:
  - stall=0; MEM/WB loads the instruction with the captured read data (or a bubble if timed out); go IDLE.
  - dmem_ready is ignored in IDLE and DONE.
- Latency:
  - Non-memory instruction: 0 stall cycles.
  - Memory op: 1 + N + 1 cycles in MEM, where N ≥ 1 is the number of WAIT cycles up to and including the dmem_ready cycle. Stall is asserted for 1 + N cycles.
- MEM/WB register:
  - Loads every cycle with stall=0.
  - With stall=1 it loads a bubble: all outputs 0, so writeback never repeats.
  - Stores keep regWrite_in as given (0 for STUR).
- Branch logic:
  - pc_src = (UnconBranch_in | ZeroBranch_in&alu_zero_in) & !stall, combinational.
  - branch_target = shifted_PC_in.
- Fault output: mem_fault is a registered pulse, exactly 1 cycle per faulting instruction.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, WAIT, DONE};
  - DATA_W, REG_W and TIMEOUT_CYCLES defaults;
  - the alignment mask constant.
- Sub-module mem_wb_pipe: the MEM/WB register with async reset and a bubble input.
- mem_stage holds the FSM, request registers, counter and branch logic.

Test Plan:
- Reset: RESET pulsed mid-WAIT -> dmem_req=0 and stall=0 the same cycle; all wb_* outputs 0; state IDLE.
- Load: memRead=1, addr=0x40, dmem_ready after 3 WAIT cycles with rdata=0xDEADBEEF -> stall high 4 cycles; next cycle wb_read_data_out=0xDEADBEEF and wb_regWrite_out=1, with bubbles in between.
- Store: memWrite=1, addr=0x08, wdata=0x55, ready immediately -> dmem_we=1 and dmem_addr=0x08 held for 1 cycle; stall 2 cycles; wb_regWrite_out=0.
- Branch: UnconBranch=1, shifted_PC=0x100 -> pc_src=1 and branch_target=0x100 the same cycle. ZeroBranch=1 with alu_zero=0 -> pc_src=0.
- Misaligned: memRead with addr=0x43 -> no dmem_req, stall=0, MEM/WB bubble, mem_fault pulses 1 cycle.
- Timeout: memRead with dmem_ready never asserted -> dmem_req drops after 16 WAIT cycles; mem_fault pulses once; MEM/WB bubble; FSM back in IDLE 2 cycles later.
